// File: rtl/decode_ctrl_pipe_if.sv
// decode_ctrl_pipe_if: IF/ID inputs, EX feedback and registered ID/EX control bundle
interface decode_ctrl_pipe_if #(parameter int REG_W = 5);
    logic [31:0] instr_i;
    logic instr_valid_i, stall_i, flush_i, ex_memread_i;
    logic [REG_W-1:0] ex_rd_i;
    logic id_ready_o, hazard_o, ex_valid_o;
    logic ex_regwrite_o, ex_alusrc_o, ex_memwrite_o, ex_memread_o;
    logic ex_branch_o, ex_jump_o, ex_jalr_o, ex_asel_pc_o;
    logic [3:0] ex_aluctrl_o;
    logic [2:0] ex_immsrc_o, ex_funct3_o;
    logic [1:0] ex_resultsrc_o, halt_cause_o;
    logic [REG_W-1:0] ex_rd_o, ex_rs1_o, ex_rs2_o;
    logic halted_o;
    modport master (
        output instr_i, instr_valid_i, stall_i, flush_i, ex_rd_i, ex_memread_i,
        input id_ready_o, hazard_o, ex_valid_o, ex_regwrite_o, ex_alusrc_o, ex_memwrite_o,
        ex_memread_o, ex_branch_o, ex_jump_o, ex_jalr_o, ex_asel_pc_o, ex_aluctrl_o,
        ex_immsrc_o, ex_resultsrc_o, ex_funct3_o, ex_rd_o, ex_rs1_o, ex_rs2_o,
        halted_o, halt_cause_o
    );
    modport slave (
        input instr_i, instr_valid_i, stall_i, flush_i, ex_rd_i, ex_memread_i,
        output id_ready_o, hazard_o, ex_valid_o, ex_regwrite_o, ex_alusrc_o, ex_memwrite_o,
        ex_memread_o, ex_branch_o, ex_jump_o, ex_jalr_o, ex_asel_pc_o, ex_aluctrl_o,
        ex_immsrc_o, ex_resultsrc_o, ex_funct3_o, ex_rd_o, ex_rs1_o, ex_rs2_o,
        halted_o, halt_cause_o
    );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: RV32I ID-stage decoder with ID/EX register and drain/halt FSM.
// Define HAZARD_DETECT_EN to enable load-use hazard detection (otherwise hazard_o = 0).
module decode_ctrl_pipe #(
    parameter int DRAIN_CYCLES = 3,
    parameter int REG_W = 5
) (
    input logic clk,
    input logic rst,
    decode_ctrl_pipe_if.slave bus
);
    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
    typedef struct packed {
        logic valid, regwrite, alusrc, memwrite, memread, branch, jump, jalr, asel_pc;
        logic [3:0] aluctrl;
        logic [2:0] immsrc;
        logic [1:0] resultsrc;
        logic [2:0] funct3;
        logic [REG_W-1:0] rd, rs1, rs2;
    } ctrl_t;
    localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0] cause, cause_n, dec_cause;
    ctrl_t dec, q;
    logic rs1_used, rs2_used, take;
    logic [6:0] op, f7;
    logic [2:0] f3;
    assign op = bus.instr_i[6:0];
    assign f3 = bus.instr_i[14:12];
    assign f7 = bus.instr_i[31:25];
    function automatic logic [3:0] alu_op(input logic [2:0] f, input logic alt);
        case (f)
            3'b000: alu_op = alt ? 4'b0001 : 4'b0000;
            3'b001: alu_op = 4'b0010;
            3'b010: alu_op = 4'b0011;
            3'b011: alu_op = 4'b0100;
            3'b100: alu_op = 4'b0101;
            3'b101: alu_op = alt ? 4'b1001 : 4'b1000;
            3'b110: alu_op = 4'b0110;
            default: alu_op = 4'b0111;
        endcase
    endfunction
    // dec_cause doubles as the legality flag: nonzero means system or illegal
    always_comb begin
        dec = '0;
        dec_cause = 2'b00;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        dec.valid = 1'b1;
        dec.funct3 = f3;
        dec.rd = REG_W'(bus.instr_i[11:7]);
        dec.rs1 = REG_W'(bus.instr_i[19:15]);
        dec.rs2 = REG_W'(bus.instr_i[24:20]);
        case (op)
            7'b0110011: begin
                dec.regwrite = 1'b1;
                dec.aluctrl = alu_op(f3, bus.instr_i[30]);
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                dec_cause = (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) ? 2'b00 : 2'b11;
            end
            7'b0010011: begin
                dec.regwrite = 1'b1;
                dec.alusrc = 1'b1;
                dec.aluctrl = alu_op(f3, f3 == 3'b101 && bus.instr_i[30]);
                rs1_used = 1'b1;
                dec_cause = ((f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && {f7[6], f7[4:0]} != 6'h00)) ? 2'b11 : 2'b00;
            end
            7'b0000011: begin
                dec.regwrite = 1'b1;
                dec.alusrc = 1'b1;
                dec.memread = 1'b1;
                dec.resultsrc = 2'b01;
                rs1_used = 1'b1;
                dec_cause = (f3 == 3'b011 || f3[2:1] == 2'b11) ? 2'b11 : 2'b00;
            end
            7'b0100011: begin
                dec.alusrc = 1'b1;
                dec.memwrite = 1'b1;
                dec.immsrc = 3'b001;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                dec_cause = (f3[2] || f3 == 3'b011) ? 2'b11 : 2'b00;
            end
            7'b1100011: begin
                dec.branch = 1'b1;
                dec.immsrc = 3'b010;
                dec.aluctrl = f3[2] ? (f3[1] ? 4'b0100 : 4'b0011) : 4'b0001;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                dec_cause = (f3[2:1] == 2'b01) ? 2'b11 : 2'b00;
            end
            7'b1101111: begin
                dec.regwrite = 1'b1;
                dec.jump = 1'b1;
                dec.immsrc = 3'b100;
                dec.resultsrc = 2'b10;
            end
            7'b1100111: begin
                dec.regwrite = 1'b1;
                dec.jalr = 1'b1;
                dec.alusrc = 1'b1;
                dec.resultsrc = 2'b10;
                rs1_used = 1'b1;
            end
            7'b0110111: begin
                dec.regwrite = 1'b1;
                dec.alusrc = 1'b1;
                dec.aluctrl = 4'b1010;
                dec.immsrc = 3'b011;
            end
            7'b0010111: begin
                dec.regwrite = 1'b1;
                dec.alusrc = 1'b1;
                dec.asel_pc = 1'b1;
                dec.immsrc = 3'b011;
            end
            7'b1110011: dec_cause = bus.instr_i == 32'h0000_0073 ? 2'b01 : bus.instr_i == 32'h0010_0073 ? 2'b10 : 2'b11;
            default: dec_cause = 2'b11;
        endcase
    end
`ifdef HAZARD_DETECT_EN
    assign bus.hazard_o = bus.ex_memread_i && bus.ex_rd_i != '0 && bus.instr_valid_i && state == RUN &&
                          ((bus.ex_rd_i == dec.rs1 && rs1_used) || (bus.ex_rd_i == dec.rs2 && rs2_used));
`else
    logic unused_hazard_in;
    assign unused_hazard_in = ^{bus.ex_rd_i, bus.ex_memread_i};
    assign bus.hazard_o = 1'b0;
`endif
    assign bus.id_ready_o = state == RUN && !bus.stall_i && !bus.hazard_o;
    assign take = bus.id_ready_o && bus.instr_valid_i && !bus.flush_i;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        cause_n = cause;
        case (state)
            RUN: if (take && dec_cause != 2'b00) begin
                state_n = DRAIN;
                cnt_n = CW'(DRAIN_CYCLES - 1);
                cause_n = dec_cause;
            end
            DRAIN: if (bus.flush_i) begin
                state_n = RUN;
                cause_n = 2'b00;
            end else if (cnt == '0) state_n = HALT;
            else cnt_n = cnt - CW'(1);
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt <= '0;
            cause <= 2'b00;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            cause <= cause_n;
        end
    end
    // system/illegal instructions are consumed but enter EX as bubbles
    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) q <= '0;
        else if (!bus.stall_i) q <= (take && dec_cause == 2'b00) ? dec : '0;
    end
    assign {bus.ex_valid_o, bus.ex_regwrite_o, bus.ex_alusrc_o, bus.ex_memwrite_o, bus.ex_memread_o,
            bus.ex_branch_o, bus.ex_jump_o, bus.ex_jalr_o, bus.ex_asel_pc_o, bus.ex_aluctrl_o,
            bus.ex_immsrc_o, bus.ex_resultsrc_o, bus.ex_funct3_o, bus.ex_rd_o, bus.ex_rs1_o, bus.ex_rs2_o} = q;
    assign bus.halted_o = state == HALT;
    assign bus.halt_cause_o = cause;
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: directed plus random stimulus, scoreboard against a spec-level model.
module tb_decode_ctrl_pipe;
    localparam int DC = 3;
    typedef struct packed {
        logic valid, regwrite, alusrc, memwrite, memread, branch, jump, jalr, asel_pc;
        logic [3:0] aluctrl;
        logic [2:0] immsrc;
        logic [1:0] resultsrc;
        logic [2:0] funct3;
        logic [4:0] rd, rs1, rs2;
    } bun_t;
    typedef struct packed {
        bun_t b;
        logic ready, hz, halted;
        logic [1:0] cause;
    } rec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    decode_ctrl_pipe_if #(.REG_W(5)) bus ();
    decode_ctrl_pipe #(.DRAIN_CYCLES(DC), .REG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
    rec_t sb[$];
    rec_t e;
    bun_t act;
    int tests = 0;
    int fails = 0;
    bun_t m_b = '0;
    int m_mode = 0;
    int m_left = 0;
    logic [1:0] m_cause = 2'b00;
    function automatic logic [3:0] alu_code(input string m);
        case (m)
            "ADD": return 4'd0;
            "SUB": return 4'd1;
            "SLL": return 4'd2;
            "SLT": return 4'd3;
            "SLTU": return 4'd4;
            "XOR": return 4'd5;
            "OR": return 4'd6;
            "AND": return 4'd7;
            "SRL": return 4'd8;
            "SRA": return 4'd9;
            "LUI": return 4'd10;
            default: return 4'd15;
        endcase
    endfunction
    function automatic string alu_name(input logic [2:0] f3, input logic alt);
        string names[8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
        string n = names[f3];
        if (alt && n == "ADD") n = "SUB";
        if (alt && n == "SRL") n = "SRA";
        return n;
    endfunction
    function automatic void model_dec(input logic [31:0] ins, output bun_t b, output logic [1:0] cause,
                                      output logic u1, output logic u2);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        b = '0;
        b.valid = 1'b1;
        b.funct3 = f3;
        b.rd = ins[11:7];
        b.rs1 = ins[19:15];
        b.rs2 = ins[24:20];
        cause = 2'b00;
        u1 = 1'b0;
        u2 = 1'b0;
        case (op)
            7'h33: begin
                u1 = 1'b1; u2 = 1'b1; b.regwrite = 1'b1;
                b.aluctrl = alu_code(alu_name(f3, f7 == 7'h20));
                if (!(f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}))) cause = 2'b11;
            end
            7'h13: begin
                u1 = 1'b1; b.regwrite = 1'b1; b.alusrc = 1'b1;
                b.aluctrl = alu_code(alu_name(f3, f3 == 3'd5 && f7[5]));
                if ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && (f7 & 7'h5f) != 7'h00)) cause = 2'b11;
            end
            7'h03: begin
                u1 = 1'b1; b.regwrite = 1'b1; b.alusrc = 1'b1; b.memread = 1'b1; b.resultsrc = 2'b01;
                if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) cause = 2'b11;
            end
            7'h23: begin
                u1 = 1'b1; u2 = 1'b1; b.alusrc = 1'b1; b.memwrite = 1'b1; b.immsrc = 3'd1;
                if (!(f3 inside {3'd0, 3'd1, 3'd2})) cause = 2'b11;
            end
            7'h63: begin
                u1 = 1'b1; u2 = 1'b1; b.branch = 1'b1; b.immsrc = 3'd2;
                b.aluctrl = alu_code(f3 inside {3'd0, 3'd1} ? "SUB" : f3 inside {3'd4, 3'd5} ? "SLT" : "SLTU");
                if (f3 inside {3'd2, 3'd3}) cause = 2'b11;
            end
            7'h6f: begin b.regwrite = 1'b1; b.jump = 1'b1; b.immsrc = 3'd4; b.resultsrc = 2'b10; end
            7'h67: begin u1 = 1'b1; b.regwrite = 1'b1; b.jalr = 1'b1; b.alusrc = 1'b1; b.resultsrc = 2'b10; end
            7'h37: begin b.regwrite = 1'b1; b.alusrc = 1'b1; b.aluctrl = alu_code("LUI"); b.immsrc = 3'd3; end
            7'h17: begin b.regwrite = 1'b1; b.alusrc = 1'b1; b.asel_pc = 1'b1; b.immsrc = 3'd3; end
            7'h73: cause = ins == 32'h0000_0073 ? 2'b01 : ins == 32'h0010_0073 ? 2'b10 : 2'b11;
            default: cause = 2'b11;
        endcase
    endfunction
    task automatic step(input logic r, input logic [31:0] ins, input logic v, input logic st,
                        input logic fl, input logic [4:0] erd, input logic emr);
        bun_t d;
        logic [1:0] dc;
        logic u1, u2, hz, rdy, take;
        rec_t rec;
        @(posedge clk);
        #2;
        rst = r;
        bus.instr_i = ins;
        bus.instr_valid_i = v;
        bus.stall_i = st;
        bus.flush_i = fl;
        bus.ex_rd_i = erd;
        bus.ex_memread_i = emr;
        model_dec(ins, d, dc, u1, u2);
`ifdef HAZARD_DETECT_EN
        hz = emr && erd != 5'd0 && v && m_mode == 0 && ((erd == d.rs1 && u1) || (erd == d.rs2 && u2));
`else
        hz = 1'b0;
`endif
        rdy = m_mode == 0 && !st && !hz;
        rec.b = m_b;
        rec.ready = rdy;
        rec.hz = hz;
        rec.halted = m_mode == 2;
        rec.cause = m_cause;
        sb.push_back(rec);
        take = rdy && v && !fl;
        if (r) begin
            m_b = '0; m_mode = 0; m_left = 0; m_cause = 2'b00;
        end else begin
            if (fl) m_b = '0;
            else if (st) m_b = m_b;
            else if (hz) m_b = '0;
            else if (take && dc == 2'b00) m_b = d;
            else m_b = '0;
            if (m_mode == 0 && take && dc != 2'b00) begin
                m_mode = 1; m_left = DC; m_cause = dc;
            end else if (m_mode == 1) begin
                if (fl) begin
                    m_mode = 0; m_cause = 2'b00;
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = 2;
                end
            end
        end
    endtask
    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, a, x, $time);
        end
    endtask
    initial forever begin
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            act = {bus.ex_valid_o, bus.ex_regwrite_o, bus.ex_alusrc_o, bus.ex_memwrite_o, bus.ex_memread_o,
                   bus.ex_branch_o, bus.ex_jump_o, bus.ex_jalr_o, bus.ex_asel_pc_o, bus.ex_aluctrl_o,
                   bus.ex_immsrc_o, bus.ex_resultsrc_o, bus.ex_funct3_o, bus.ex_rd_o, bus.ex_rs1_o, bus.ex_rs2_o};
            chk("id_ex_bundle", 64'(act), 64'(e.b));
            chk("ready_hazard", {62'd0, bus.id_ready_o, bus.hazard_o}, {62'd0, e.ready, e.hz});
            chk("halt_state", {61'd0, bus.halted_o, bus.halt_cause_o}, {61'd0, e.halted, e.cause});
        end
    end
    function automatic logic [2:0] pick_f3(input int cls);
        logic [2:0] f = 3'($urandom);
        if ($urandom_range(0, 19) == 0) return f;
        case (cls)
            0: while (!(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) f = 3'($urandom);
            1: while (!(f inside {3'd0, 3'd1, 3'd2})) f = 3'($urandom);
            default: while (f inside {3'd2, 3'd3}) f = 3'($urandom);
        endcase
        return f;
    endfunction
    function automatic logic [31:0] rand_instr();
        int k = $urandom_range(0, 99);
        logic [4:0] rd = 5'($urandom_range(0, 7));
        logic [4:0] r1 = 5'($urandom_range(0, 7));
        logic [4:0] r2 = 5'($urandom_range(0, 7));
        logic [2:0] f3 = 3'($urandom);
        int p = $urandom_range(0, 99);
        logic [6:0] f7 = p < 60 ? 7'h00 : p < 98 ? 7'h20 : 7'($urandom);
        logic [11:0] imm = 12'($urandom);
        logic [19:0] up = 20'($urandom);
        if (k < 25) return {f7, r2, r1, f3, rd, 7'h33};
        if (k < 45) return (f3 == 3'd1 || f3 == 3'd5) ? {f7, r2, r1, f3, rd, 7'h13} : {imm, r1, f3, rd, 7'h13};
        if (k < 57) return {imm, r1, pick_f3(0), rd, 7'h03};
        if (k < 67) return {imm[11:5], r2, r1, pick_f3(1), imm[4:0], 7'h23};
        if (k < 80) return {imm[11:5], r2, r1, pick_f3(2), imm[4:0], 7'h63};
        if (k < 85) return {up, rd, 7'h6f};
        if (k < 90) return {imm, r1, 3'd0, rd, 7'h67};
        if (k < 94) return {up, rd, 7'h37};
        if (k < 98) return {up, rd, 7'h17};
        if (k < 99) return p < 40 ? 32'h0000_0073 : p < 80 ? 32'h0010_0073 : {25'($urandom), 7'h73};
        return {25'($urandom), 7'($urandom)};
    endfunction
    initial begin
        bus.instr_i = '0;
        bus.instr_valid_i = 1'b0;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.ex_rd_i = '0;
        bus.ex_memread_i = 1'b0;
        step(1, 32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h002081B3, 1, 0, 0, 0, 0);
        step(0, 32'h402081B3, 1, 0, 0, 0, 0);
        step(0, 32'h0000A183, 1, 0, 0, 0, 0);
        step(0, 32'h00318233, 1, 0, 0, 5'd3, 1);
        step(0, 32'h00318233, 1, 0, 0, 0, 0);
        step(0, 32'h0020A423, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 32'h002081B3, 1, 1, 0, 0, 0);
        step(0, 32'h002081B3, 1, 1, 1, 0, 0);
        step(0, 32'h00100073, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 32'h002081B3, 1, 0, 0, 0, 0);
        step(1, 32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h00000073, 1, 0, 0, 0, 0);
        step(0, 32'h002081B3, 1, 0, 0, 0, 0);
        step(0, 32'h002081B3, 1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 32'h002081B3, 1, 0, 0, 0, 0);
        step(0, 32'h0000B003, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 0, 0, 0, 0);
        step(1, 32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h0020A063, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 0, 0, 0, 0);
        step(1, 32'h0, 0, 0, 0, 0, 0);
        step(0, 32'h0020C463, 1, 0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 49) == 0, rand_instr(), $urandom_range(0, 9) != 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
